// File: rtl/m_rr_mux.sv
// N-channel, W-bit registered multiplexer with round-robin arbitration and valid/ready on both sides.
// Optional RR_MUX_FORCE_SEL_EN adds w_force/w_fsel to override arbitration with a fixed channel.
module m_rr_mux #(
    parameter int W = 8,
    parameter int N = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            w_clk,
    input  logic            w_rst,
    input  logic [N-1:0]    w_ivld,
    input  logic [N*W-1:0]  w_idata,
    output logic [N-1:0]    w_irdy,
    output logic            w_ovld,
    output logic [W-1:0]    w_odata,
    output logic [CW-1:0]   w_och,
    input  logic            w_ordy
`ifdef RR_MUX_FORCE_SEL_EN
    ,
    input  logic            w_force,
    input  logic [CW-1:0]   w_fsel
`endif
);

    logic [CW-1:0] ptr_r;
    logic          ovld_r;
    logic [W-1:0]  odata_r;
    logic [CW-1:0] och_r;

    logic          load_s;
    logic          gnt_vld_s;
    logic [CW-1:0] gnt_idx_s;
    logic          xfer_s;
    logic          adv_s;

    // (base + off) mod N for base < N and off < N
    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return CW'(sum);
    endfunction

    assign load_s = !ovld_r || w_ordy;

    // Grant selection: first valid channel at or after the pointer, or the forced channel
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = {CW{1'b0}};
        adv_s     = 1'b1;
`ifdef RR_MUX_FORCE_SEL_EN
        if (w_force) begin
            adv_s = 1'b0;
            if ((int'(w_fsel) < N) && w_ivld[w_fsel]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = w_fsel;
            end else begin
                gnt_vld_s = 1'b0;
            end
        end else begin
`endif
            for (int k = 0; k < N; k++) begin
                if (!gnt_vld_s && w_ivld[wrap_add(ptr_r, k)]) begin
                    gnt_vld_s = 1'b1;
                    gnt_idx_s = wrap_add(ptr_r, k);
                end else begin
                    gnt_vld_s = gnt_vld_s;
                end
            end
`ifdef RR_MUX_FORCE_SEL_EN
        end
`endif
    end

    // Ready only reaches w_ordy through load, never from the valids back to the consumer
    assign xfer_s = gnt_vld_s && load_s && !w_rst;
    assign w_irdy = {N{xfer_s}} & (N'(1'b1) << gnt_idx_s);

    // Output stage and round-robin pointer update
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            ovld_r  <= 1'b0;
            odata_r <= {W{1'b0}};
            och_r   <= {CW{1'b0}};
            ptr_r   <= {CW{1'b0}};
        end else if (load_s) begin
            if (xfer_s) begin
                ovld_r  <= 1'b1;
                odata_r <= w_idata[gnt_idx_s*W +: W];
                och_r   <= gnt_idx_s;
                if (adv_s) begin
                    ptr_r <= wrap_add(gnt_idx_s, 1);
                end else begin
                    ptr_r <= ptr_r;
                end
            end else begin
                ovld_r  <= 1'b0;
                odata_r <= odata_r;
                och_r   <= och_r;
                ptr_r   <= ptr_r;
            end
        end else begin
            ovld_r  <= ovld_r;
            odata_r <= odata_r;
            och_r   <= och_r;
            ptr_r   <= ptr_r;
        end
    end

    assign w_ovld  = ovld_r;
    assign w_odata = odata_r;
    assign w_och   = och_r;

endmodule
